// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase codes, timer-mux select values and one-hot light encodings.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALL_RED     = 3'd0,
        MAIN_GREEN  = 3'd1,
        MAIN_YELLOW = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        PROG_HOLD   = 3'd5
    } phase_e;

    // Timer-mux select codes: which register-bank duration the countdown timer reloads from.
    localparam logic [1:0] SEL_MAIN  = 2'b00;
    localparam logic [1:0] SEL_SIDE  = 2'b01;
    localparam logic [1:0] SEL_AMBER = 2'b10;

    // Lamp drive, {R,Y,G} one-hot.
    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    function automatic logic [2:0] main_light_of(input phase_e p);
        case (p)
            MAIN_GREEN:  return LIGHT_G;
            MAIN_YELLOW: return LIGHT_Y;
            default:     return LIGHT_R;
        endcase
    endfunction

    function automatic logic [2:0] side_light_of(input phase_e p);
        case (p)
            SIDE_GREEN:  return LIGHT_G;
            SIDE_YELLOW: return LIGHT_Y;
            default:     return LIGHT_R;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// traffic_phase_sequencer_if: control/status bundle between the sequencer and the intersection datapath.
// Latency: none, wires only.
// Backpressure: none; side_demand is present only when SIDE_DEMAND_EN is defined.
interface traffic_phase_sequencer_if;
    import traffic_pkg::*;

    logic       enable;
    logic       timer_trigger;
    logic       prog_req;
`ifdef SIDE_DEMAND_EN
    logic       side_demand;
`endif
    logic [1:0] timer_select;
    logic       timer_load;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       prog_ack;
    phase_e     phase;

    // Datapath / environment side: issues requests, observes lamps and timer control.
    modport master (
`ifdef SIDE_DEMAND_EN
        output side_demand,
`endif
        output enable, timer_trigger, prog_req,
        input  timer_select, timer_load, main_light, side_light, prog_ack, phase
    );

    // Sequencer side.
    modport slave (
`ifdef SIDE_DEMAND_EN
        input  side_demand,
`endif
        input  enable, timer_trigger, prog_req,
        output timer_select, timer_load, main_light, side_light, prog_ack, phase
    );

endinterface

// File: rtl/timer_expiry_detect.sv
// timer_expiry_detect: synchronises the countdown-timer trigger and emits a one-cycle expiry on its armed rising edge.
// Latency: expire asserts 2 cycles after trigger rises (two sync flops, edge detect is combinational on the sync output).
// Backpressure: none; load clears the arm flag so a trigger left high across a reload is ignored until it drops.
module timer_expiry_detect (
    input  logic clock,
    input  logic reset,
    input  logic trigger,
    input  logic load,
    output logic expire
);

    logic [1:0] sync;
    logic       prev;
    logic       armed;

    // Sync pipeline, edge history and arm flag (re-armed only after a low sample).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync  <= 2'b00;
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync <= {sync[0], trigger};
            prev <= sync[1];
            if (load) begin
                armed <= 1'b0;
            end else if (!sync[1]) begin
                armed <= 1'b1;
            end
        end
    end

    // A rising edge coinciding with a reload belongs to the previous interval, so it is dropped.
    assign expire = sync[1] & ~prev & armed & ~load;

endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: light-phase FSM, all-red clearance counter and timer-mux/load control.
// Latency: outputs registered, one cycle after the transition decision; trigger-to-decision is 2 cycles.
// Backpressure: none; enable/prog_req are sampled only at the end of all-red. SIDE_DEMAND_EN adds main-green extension.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int ALL_RED_CYCLES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    traffic_phase_sequencer_if.slave bus
);

    localparam int               CNT_W      = (ALL_RED_CYCLES > 1) ? $clog2(ALL_RED_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(ALL_RED_CYCLES - 1);

    phase_e           state;
    phase_e           nxt_state;
    logic [CNT_W-1:0] clr_cnt;
    logic [CNT_W-1:0] nxt_clr_cnt;
    logic             last_main;      // last yellow shown was on the main road
    logic             nxt_last_main;
    logic [1:0]       sel_q;
    logic [1:0]       nxt_sel;
    logic             load_q;
    logic             nxt_load;
    logic [2:0]       main_q;
    logic [2:0]       side_q;
    logic             ack_q;
    logic             expire;
    logic             idle;
    logic             hold_green;

    // Trigger is meaningless while no timed phase runs; keep the arm flag cleared there.
    assign idle = (state == ALL_RED) || (state == PROG_HOLD);

`ifdef SIDE_DEMAND_EN
    // No waiting side traffic and no programming request: main green keeps re-timing.
    assign hold_green = !bus.side_demand && !bus.prog_req;
`else
    assign hold_green = 1'b0;
`endif

    timer_expiry_detect u_expiry (
        .clock   (clock),
        .reset   (reset),
        .trigger (bus.timer_trigger),
        .load    (load_q | idle),
        .expire  (expire)
    );

    // Next-state, clearance counter and timer-control decisions.
    always_comb begin
        nxt_state     = state;
        nxt_clr_cnt   = clr_cnt;
        nxt_last_main = last_main;
        nxt_sel       = sel_q;
        nxt_load      = 1'b0;
        case (state)
            ALL_RED: begin
                if (clr_cnt != '0) begin
                    nxt_clr_cnt = clr_cnt - 1'b1;
                end else if (bus.prog_req) begin
                    nxt_state = PROG_HOLD;
                end else if (bus.enable) begin
                    nxt_load = 1'b1;
                    if (last_main) begin
                        nxt_state = SIDE_GREEN;
                        nxt_sel   = SEL_SIDE;
                    end else begin
                        nxt_state = MAIN_GREEN;
                        nxt_sel   = SEL_MAIN;
                    end
                end
            end
            MAIN_GREEN: begin
                if (expire) begin
                    nxt_load = 1'b1;
                    if (!hold_green) begin
                        nxt_state = MAIN_YELLOW;
                        nxt_sel   = SEL_AMBER;
                    end
                end
            end
            SIDE_GREEN: begin
                if (expire) begin
                    nxt_state = SIDE_YELLOW;
                    nxt_sel   = SEL_AMBER;
                    nxt_load  = 1'b1;
                end
            end
            MAIN_YELLOW: begin
                if (expire) begin
                    nxt_state     = ALL_RED;
                    nxt_clr_cnt   = CLEAR_LOAD;
                    nxt_last_main = 1'b1;
                end
            end
            SIDE_YELLOW: begin
                if (expire) begin
                    nxt_state     = ALL_RED;
                    nxt_clr_cnt   = CLEAR_LOAD;
                    nxt_last_main = 1'b0;
                end
            end
            PROG_HOLD: begin
                // Leaving programming restarts the cycle on the main road after full clearance.
                if (!bus.prog_req) begin
                    nxt_state     = ALL_RED;
                    nxt_clr_cnt   = CLEAR_LOAD;
                    nxt_last_main = 1'b0;
                end
            end
            default: begin
                nxt_state   = ALL_RED;
                nxt_clr_cnt = CLEAR_LOAD;
            end
        endcase
    end

    // State register plus registered outputs decoded from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ALL_RED;
            clr_cnt   <= CLEAR_LOAD;
            last_main <= 1'b0;
            sel_q     <= SEL_MAIN;
            load_q    <= 1'b0;
            main_q    <= LIGHT_R;
            side_q    <= LIGHT_R;
            ack_q     <= 1'b0;
        end else begin
            state     <= nxt_state;
            clr_cnt   <= nxt_clr_cnt;
            last_main <= nxt_last_main;
            sel_q     <= nxt_sel;
            load_q    <= nxt_load;
            main_q    <= main_light_of(nxt_state);
            side_q    <= side_light_of(nxt_state);
            ack_q     <= (nxt_state == PROG_HOLD);
        end
    end

    assign bus.timer_select = sel_q;
    assign bus.timer_load   = load_q;
    assign bus.main_light   = main_q;
    assign bus.side_light   = side_q;
    assign bus.prog_ack     = ack_q;
    assign bus.phase        = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer: directed phase walks plus randomized requests against a phase-rule model.
// Timing: inputs driven and outputs sampled on the falling clock edge.
// Builds with or without SIDE_DEMAND_EN; the main-green extension checks exist only when it is defined.
module tb_traffic_phase_sequencer;
    import traffic_pkg::*;

    localparam int AR_CYC = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    traffic_phase_sequencer_if bus ();

    traffic_phase_sequencer #(.ALL_RED_CYCLES(AR_CYC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int     total = 0;
    int     bad   = 0;
    phase_e cur;          // phase the model believes the DUT is in
    bit     last_main;    // model: last yellow was on the main road
    bit     rand_en;
    phase_e order [$];
    phase_e want  [7];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic bit is_timed(input phase_e p);
        return (p == MAIN_GREEN) || (p == MAIN_YELLOW) || (p == SIDE_GREEN) || (p == SIDE_YELLOW);
    endfunction

    function automatic logic [1:0] sel_for(input phase_e p);
        if (p == MAIN_GREEN) return 2'b00;
        if (p == SIDE_GREEN) return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [2:0] main_for(input phase_e p);
        if (p == MAIN_GREEN)  return 3'b001;
        if (p == MAIN_YELLOW) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] side_for(input phase_e p);
        if (p == SIDE_GREEN)  return 3'b001;
        if (p == SIDE_YELLOW) return 3'b010;
        return 3'b100;
    endfunction

    function automatic bit green_extends();
`ifdef SIDE_DEMAND_EN
        return !bus.side_demand && !bus.prog_req;
`else
        return 1'b0;
`endif
    endfunction

    function automatic phase_e after_expiry(input phase_e p);
        case (p)
            MAIN_GREEN: return green_extends() ? MAIN_GREEN : MAIN_YELLOW;
            SIDE_GREEN: return SIDE_YELLOW;
            default:    return ALL_RED;
        endcase
    endfunction

    task automatic randomize_inputs();
        bus.enable   = ($urandom_range(0, 9) != 0);
        bus.prog_req = ($urandom_range(0, 7) == 0);
`ifdef SIDE_DEMAND_EN
        bus.side_demand = 1'($urandom_range(0, 1));
`endif
    endtask

    // Called on the first sampled cycle of a phase the model expects the DUT to be in.
    task automatic check_entry(input phase_e p);
        check_eq("phase", bus.phase, p);
        check_eq("load", bus.timer_load, is_timed(p));
        if (is_timed(p)) check_eq("select", bus.timer_select, sel_for(p));
        check_eq("main_light", bus.main_light, main_for(p));
        check_eq("side_light", bus.side_light, side_for(p));
        check_eq("prog_ack", bus.prog_ack, p == PROG_HOLD);
        cur = p;
        if (rand_en && is_timed(p)) randomize_inputs();
    endtask

    task automatic pulse_and_wait(input phase_e p, input int w, output bit seen);
        seen = 1'b0;
        bus.timer_trigger = 1'b1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            tick();
            if (k == w) bus.timer_trigger = 1'b0;
            seen = (bus.phase != p) || bus.timer_load;
        end
        bus.timer_trigger = 1'b0;
    endtask

    task automatic run_timed();
        phase_e p;
        phase_e nxt;
        bit     seen;
        p   = cur;
        nxt = after_expiry(p);
        repeat ($urandom_range(2, 6)) begin
            tick();
            check_eq("hold_phase", bus.phase, p);
            check_eq("hold_load", bus.timer_load, 0);
        end
        pulse_and_wait(p, $urandom_range(1, 3), seen);
        check_eq("expiry_seen", seen, 1);
        if (p == MAIN_YELLOW) last_main = 1'b1;
        if (p == SIDE_YELLOW) last_main = 1'b0;
        check_entry(nxt);
    endtask

    task automatic run_all_red();
        int     n;
        phase_e nxt;
        n = 1;
        if (!bus.prog_req && !bus.enable) begin
            repeat (3 * AR_CYC) begin
                tick();
                check_eq("park_phase", bus.phase, ALL_RED);
                check_eq("park_load", bus.timer_load, 0);
            end
            bus.enable = 1'b1;
            tick();
            check_entry(last_main ? SIDE_GREEN : MAIN_GREEN);
            return;
        end
        nxt = bus.prog_req ? PROG_HOLD : (last_main ? SIDE_GREEN : MAIN_GREEN);
        while (n < 4 * AR_CYC) begin
            tick();
            if (bus.phase != ALL_RED) break;
            n++;
        end
        check_eq("ar_cycles", n, AR_CYC);
        check_entry(nxt);
    endtask

    task automatic run_hold();
        repeat ($urandom_range(2, 6)) begin
            tick();
            check_eq("ph_phase", bus.phase, PROG_HOLD);
            check_eq("ph_ack", bus.prog_ack, 1);
            check_eq("ph_load", bus.timer_load, 0);
        end
        bus.prog_req = 1'b0;
        tick();
        last_main = 1'b0;
        check_entry(ALL_RED);
    endtask

    task automatic step();
        case (cur)
            ALL_RED:   run_all_red();
            PROG_HOLD: run_hold();
            default:   run_timed();
        endcase
    endtask

    // Reset is raised between clock edges and checked before the next edge arrives.
    task automatic apply_reset();
        tick();
        #1 reset = 1'b1;
        #1;
        check_eq("rst_phase", bus.phase, ALL_RED);
        check_eq("rst_select", bus.timer_select, 2'b00);
        check_eq("rst_load", bus.timer_load, 0);
        check_eq("rst_main", bus.main_light, 3'b100);
        check_eq("rst_side", bus.side_light, 3'b100);
        check_eq("rst_ack", bus.prog_ack, 0);
        bus.timer_trigger = 1'b0;
        bus.prog_req      = 1'b0;
        bus.enable        = 1'b1;
`ifdef SIDE_DEMAND_EN
        bus.side_demand   = 1'b1;
`endif
        repeat (2) tick();
        reset     = 1'b0;
        last_main = 1'b0;
        check_entry(ALL_RED);
    endtask

    task automatic held_trigger();
        bit seen;
        seen = 1'b0;
        repeat (2) tick();
        bus.timer_trigger = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = (bus.phase != MAIN_GREEN);
        end
        check_eq("held_seen", seen, 1);
        check_entry(MAIN_YELLOW);
        repeat (8) begin
            tick();
            check_eq("held_no_expiry", bus.phase, MAIN_YELLOW);
        end
        bus.timer_trigger = 1'b0;
        repeat (4) begin
            tick();
            check_eq("held_low", bus.phase, MAIN_YELLOW);
        end
        run_timed();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable        = 1'b1;
        bus.prog_req      = 1'b0;
        bus.timer_trigger = 1'b0;
`ifdef SIDE_DEMAND_EN
        bus.side_demand   = 1'b1;
`endif
        rand_en   = 1'b0;
        last_main = 1'b0;
        cur       = ALL_RED;
        want      = '{MAIN_GREEN, MAIN_YELLOW, ALL_RED, SIDE_GREEN, SIDE_YELLOW, ALL_RED, MAIN_GREEN};

        apply_reset();

        // Full cycle in order.
        repeat (7) begin
            step();
            order.push_back(bus.phase);
        end
        for (int i = 0; i < 7; i++) check_eq("order", order[i], want[i]);

        // Trigger left high across a reload.
        held_trigger();
        step();
        check_eq("t3_sg", bus.phase, SIDE_GREEN);
        repeat (3) step();
        check_eq("t3_mg", bus.phase, MAIN_GREEN);

        // Programming request raised mid main-green.
        bus.prog_req = 1'b1;
        step(); check_eq("t4_my", bus.phase, MAIN_YELLOW);
        step(); check_eq("t4_ar", bus.phase, ALL_RED);
        step(); check_eq("t4_hold", bus.phase, PROG_HOLD);
        step(); check_eq("t4_release", bus.phase, ALL_RED);
        step(); check_eq("t4_mg", bus.phase, MAIN_GREEN);

        // Run request dropped mid side-green.
        repeat (3) step();
        check_eq("t5_sg", bus.phase, SIDE_GREEN);
        bus.enable = 1'b0;
        step(); check_eq("t5_sy", bus.phase, SIDE_YELLOW);
        step(); check_eq("t5_ar", bus.phase, ALL_RED);
        step(); check_eq("t5_mg", bus.phase, MAIN_GREEN);

`ifdef SIDE_DEMAND_EN
        // No side demand: main green re-times on every expiry.
        bus.side_demand = 1'b0;
        repeat (3) begin
            step();
            check_eq("t6_extend", bus.phase, MAIN_GREEN);
        end
        bus.side_demand = 1'b1;
        step();
        check_eq("t6_my", bus.phase, MAIN_YELLOW);
`endif

        rand_en = 1'b1;
        repeat (60) step();

        rand_en = 1'b0;
        apply_reset();
        step();
        check_eq("post_reset_mg", bus.phase, MAIN_GREEN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
